// File: rtl/mem_stage_lat.sv
// ----------------------------------------------------------------------------
// mem_stage_lat
//   Memory stage of a Y86-style pipeline with a configurable-latency data
//   memory, plus the W pipeline register that follows it.
//
//   Parameters
//     DW      : data and address width in bits
//     DEPTH   : data memory size in DW-bit words (word indexed)
//     LATENCY : memory access cycles (>= 1)
//
//   Ports
//     clk, rst                 : rising-edge clock, synchronous active-high reset
//     M_icode, M_dstE, M_dstM  : instruction code / destinations from M register
//     M_valE, M_valA           : ALU result / operand A from M register
//     M_stat                   : incoming status (1 AOK, 2 HLT, 3 ADR, 4 INS)
//     W_stall, W_bubble        : hold W, or load a NOP into W
//     W_icode .. W_stat        : W pipeline register outputs
//     m_valM, m_stat           : memory read data and memory-stage status
//     m_busy                   : stall request to the hazard unit
//
//   Optional feature (macro MEM_PERF_CNT_EN):
//     rd_count, wr_count, err_count : 32-bit wrapping access counters
// ----------------------------------------------------------------------------
module mem_stage_lat #(
  parameter int DW      = 64,
  parameter int DEPTH   = 8192,
  parameter int LATENCY = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [3:0]    M_icode,
  input  logic [3:0]    M_dstE,
  input  logic [3:0]    M_dstM,
  input  logic [DW-1:0] M_valE,
  input  logic [DW-1:0] M_valA,
  input  logic [3:0]    M_stat,
  input  logic          W_stall,
  input  logic          W_bubble,
  output logic [3:0]    W_icode,
  output logic [3:0]    W_dstE,
  output logic [3:0]    W_dstM,
  output logic [DW-1:0] W_valE,
  output logic [DW-1:0] W_valM,
  output logic [3:0]    W_stat,
  output logic [DW-1:0] m_valM,
  output logic [3:0]    m_stat,
  output logic          m_busy
`ifdef MEM_PERF_CNT_EN
  ,
  output logic [31:0]   rd_count,
  output logic [31:0]   wr_count,
  output logic [31:0]   err_count
`endif
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  localparam logic [3:0] ICODE_NOP = 4'h1;
  localparam logic [3:0] REG_NONE  = 4'hF;
  localparam logic [3:0] STAT_AOK  = 4'h1;
  localparam logic [3:0] STAT_ADR  = 4'h3;

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;

  logic [DW-1:0]   mem [DEPTH];

  logic            is_rd;
  logic            is_wr;
  logic            addr_from_vala;
  logic            is_acc;
  logic [DW-1:0]   addr;
  logic [AW-1:0]   mem_idx;
  logic            dmem_error;
  logic            access_done;
  logic            mem_we;

  // Access decode: 5 reads at valE, 9/B (ret/popl) read at valA,
  // 4/8/A write valA at valE.
  always_comb begin
    is_rd          = 1'b0;
    is_wr          = 1'b0;
    addr_from_vala = 1'b0;
    case (M_icode)
      4'h5: is_rd = 1'b1;
      4'h9, 4'hB: begin
        is_rd          = 1'b1;
        addr_from_vala = 1'b1;
      end
      4'h4, 4'h8, 4'hA: is_wr = 1'b1;
      default: ;
    endcase
  end

  assign is_acc     = is_rd | is_wr;
  assign addr       = addr_from_vala ? M_valA : M_valE;
  assign mem_idx    = addr[AW-1:0];
  // Full-width compare so aliasing high bits never reach the array.
  assign dmem_error = is_acc && (addr > DW'(DEPTH - 1));
  assign m_stat     = (dmem_error && (M_stat == STAT_AOK)) ? STAT_ADR : M_stat;

  // access_done marks the cycle in which data is valid and a write may commit.
  always_comb begin
    m_busy      = 1'b0;
    access_done = 1'b0;
    if (LATENCY == 1) begin
      access_done = is_acc && !dmem_error;
    end else begin
      case (state)
        IDLE: m_busy = is_acc && !dmem_error;
        BUSY: begin
          m_busy      = (cnt < CW'(LATENCY - 1));
          access_done = is_acc && !dmem_error && (cnt == CW'(LATENCY - 1));
        end
        default: ;
      endcase
    end
  end

  assign m_valM = (is_rd && access_done) ? mem[mem_idx] : '0;

  // A stalled final cycle repeats next cycle, so committing only on a
  // non-stalled edge gives exactly one write per access.
  assign mem_we = is_wr && access_done && !W_stall && !rst;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_idx] <= M_valA;
    end
  end

  // Latency FSM; frozen while W is stalled, stays IDLE for single-cycle memory.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else if (!W_stall && (LATENCY > 1)) begin
      case (state)
        IDLE: begin
          if (is_acc && !dmem_error) begin
            state <= BUSY;
            cnt   <= CW'(1);
          end
        end
        BUSY: begin
          if (cnt == CW'(LATENCY - 1)) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // W pipeline register.
  always_ff @(posedge clk) begin
    if (rst) begin
      W_icode <= ICODE_NOP;
      W_dstE  <= REG_NONE;
      W_dstM  <= REG_NONE;
      W_valE  <= '0;
      W_valM  <= '0;
      W_stat  <= STAT_AOK;
    end else if (W_stall) begin
      W_icode <= W_icode;
    end else if (W_bubble || m_busy) begin
      W_icode <= ICODE_NOP;
      W_dstE  <= REG_NONE;
      W_dstM  <= REG_NONE;
      W_valE  <= '0;
      W_valM  <= '0;
      W_stat  <= STAT_AOK;
    end else begin
      W_icode <= M_icode;
      W_dstE  <= M_dstE;
      W_dstM  <= M_dstM;
      W_valE  <= M_valE;
      W_valM  <= m_valM;
      W_stat  <= m_stat;
    end
  end

`ifdef MEM_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_count  <= '0;
      wr_count  <= '0;
      err_count <= '0;
    end else if (!W_stall) begin
      if (access_done && is_rd) rd_count  <= rd_count + 32'd1;
      if (access_done && is_wr) wr_count  <= wr_count + 32'd1;
      if (dmem_error)           err_count <= err_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_stage_lat.sv
module tb_mem_stage_lat;

  localparam int DW    = 64;
  localparam int DEPTH = 8192;
  localparam int LAT   = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [3:0]    M_icode, M_dstE, M_dstM, M_stat;
  logic [DW-1:0] M_valE, M_valA;
  logic          W_stall, W_bubble;
  logic [3:0]    W_icode, W_dstE, W_dstM, W_stat;
  logic [DW-1:0] W_valE, W_valM;
  logic [DW-1:0] m_valM;
  logic [3:0]    m_stat;
  logic          m_busy;
`ifdef MEM_PERF_CNT_EN
  logic [31:0]   rd_count, wr_count, err_count;
`endif

  always #5 clk = ~clk;

  mem_stage_lat #(.DW(DW), .DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .M_icode(M_icode), .M_dstE(M_dstE), .M_dstM(M_dstM),
    .M_valE(M_valE), .M_valA(M_valA), .M_stat(M_stat),
    .W_stall(W_stall), .W_bubble(W_bubble),
    .W_icode(W_icode), .W_dstE(W_dstE), .W_dstM(W_dstM),
    .W_valE(W_valE), .W_valM(W_valM), .W_stat(W_stat),
    .m_valM(m_valM), .m_stat(m_stat), .m_busy(m_busy)
`ifdef MEM_PERF_CNT_EN
    , .rd_count(rd_count), .wr_count(wr_count), .err_count(err_count)
`endif
  );

  typedef struct packed {
    logic [3:0]  icode;
    logic [3:0]  dstE;
    logic [3:0]  dstM;
    logic [63:0] valE;
    logic [63:0] valM;
    logic [3:0]  stat;
  } wreg_t;

  localparam wreg_t NOP_W = '{icode: 4'h1, dstE: 4'hF, dstM: 4'hF,
                              valE: 64'h0, valM: 64'h0, stat: 4'h1};

  wreg_t        exp_q[$];
  int           n_tests = 0;
  int           n_fail  = 0;
  logic [63:0]  mm [logic [63:0]];
  logic [63:0]  waddrs[$];
  int unsigned  m_rd = 0, m_wr = 0, m_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_idle();
    M_icode = 4'h1; M_dstE = 4'hF; M_dstM = 4'hF;
    M_valE  = '0;   M_valA = '0;   M_stat = 4'h1;
  endtask

  // Monitor: models the W register each edge from the bench's own view of
  // rst/stall/bubble and pops the scoreboard whenever a real op lands in W.
  initial begin
    wreg_t w_model, exp_w, act_w;
    logic  r, s, b;
    w_model = NOP_W;
    forever begin
      @(posedge clk);
      r = rst; s = W_stall; b = W_bubble;
      #1;
      act_w = '{icode: W_icode, dstE: W_dstE, dstM: W_dstM,
                valE: W_valE, valM: W_valM, stat: W_stat};
      if (r || (!s && (b || W_icode == 4'h1))) begin
        exp_w = NOP_W;
      end else if (s) begin
        exp_w = w_model;
      end else if (exp_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL W_unexpected: got icode 0x%0h expected no op (t=%0t)", W_icode, $time);
        exp_w = act_w;
      end else begin
        exp_w = exp_q.pop_front();
      end
      check("W_icode", 64'(act_w.icode), 64'(exp_w.icode));
      check("W_dstE",  64'(act_w.dstE),  64'(exp_w.dstE));
      check("W_dstM",  64'(act_w.dstM),  64'(exp_w.dstM));
      check("W_valE",  act_w.valE,       exp_w.valE);
      check("W_valM",  act_w.valM,       exp_w.valM);
      check("W_stat",  64'(act_w.stat),  64'(exp_w.stat));
      w_model = exp_w;
    end
  end

  // Issue one op at a negedge and hold it until the stage accepts it.
  // stall_mode < 0: W_stall forced on cycles 1..4; otherwise stall percent.
  task automatic run_op(input logic [3:0] ic, input logic [3:0] dE, input logic [3:0] dM,
                        input logic [63:0] vE, input logic [63:0] vA,
                        input logic [3:0] st, input int stall_mode);
    logic        rd, wr, err;
    logic [63:0] a, exp_valM;
    logic [3:0]  exp_stat;
    int          exp_busy, busy_n, cyc;
    bit          done;
    rd = (ic == 4'h5) || (ic == 4'h9) || (ic == 4'hB);
    wr = (ic == 4'h4) || (ic == 4'h8) || (ic == 4'hA);
    a  = (ic == 4'h9 || ic == 4'hB) ? vA : vE;
    err = (rd || wr) && (a >= 64'(DEPTH));
    exp_stat = (err && st == 4'h1) ? 4'h3 : st;
    exp_valM = '0;
    if (rd && !err) exp_valM = mm[a];
    exp_busy = ((rd || wr) && !err) ? LAT - 1 : 0;
    if (wr && !err) begin
      if (!mm.exists(a)) waddrs.push_back(a);
      mm[a] = vA;
    end
    if (rd && !err) m_rd++;
    if (wr && !err) m_wr++;
    if (err) m_err++;
    exp_q.push_back('{icode: ic, dstE: dE, dstM: dM, valE: vE, valM: exp_valM, stat: exp_stat});

    M_icode = ic; M_dstE = dE; M_dstM = dM; M_valE = vE; M_valA = vA; M_stat = st;
    busy_n = 0; cyc = 0; done = 0;
    while (!done && cyc < 40) begin
      if (stall_mode < 0) W_stall = (cyc >= 1 && cyc <= 4);
      else                W_stall = ($urandom_range(99) < stall_mode);
      #1;
      if (cyc == 0) check("m_stat", 64'(m_stat), 64'(exp_stat));
      if (!W_stall && m_busy) busy_n++;
      if (!W_stall && !m_busy) begin
        done = 1;
        check("m_valM", m_valM, exp_valM);
      end
      @(negedge clk);
      cyc++;
    end
    W_stall = 1'b0;
    if (!done) begin
      n_tests++; n_fail++;
      $display("FAIL op_timeout: got no completion after %0d cycles expected completion", cyc);
    end
    check("m_busy_cycles", 64'(busy_n), 64'(exp_busy));
  endtask

  // Present a write, pulse rst on cycle at_cyc of the access, then confirm
  // the FSM restarted from IDLE (busy re-raised for the still-pending op).
  task automatic reset_abort(input int at_cyc, input logic [63:0] addr, input logic [63:0] newv);
    M_icode = 4'hA; M_dstE = 4'h4; M_dstM = 4'hF;
    M_valE = addr;  M_valA = newv;  M_stat = 4'h1;
    repeat (at_cyc - 1) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_rd = 0; m_wr = 0; m_err = 0;
    #1;
    check("rst_W_icode", 64'(W_icode), 64'h1);
    check("rst_busy_restart", 64'(m_busy), 64'h1);
    set_idle();
    @(negedge clk);
  endtask

  task automatic check_counters();
`ifdef MEM_PERF_CNT_EN
    check("rd_count",  64'(rd_count),  64'(m_rd));
    check("wr_count",  64'(wr_count),  64'(m_wr));
    check("err_count", 64'(err_count), 64'(m_err));
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  ics [12];
    logic [3:0]  ic, st;
    logic [63:0] vE, vA, a;
    bit          rdop, wrop;
    ics = '{4'h0, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA, 4'hB, 4'hC};

    rst = 1'b1; W_stall = 1'b0; W_bubble = 1'b0;
    set_idle();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_busy", 64'(m_busy), 64'h0);
    check("reset_W_stat", 64'(W_stat), 64'h1);
    @(negedge clk);

    // write then read back with full latency
    run_op(4'h4, 4'hF, 4'hF, 64'h10, 64'hDEAD, 4'h1, 0);
    run_op(4'h5, 4'hF, 4'h3, 64'h10, 64'h0,    4'h1, 0);
    // out-of-range read, and aliasing out-of-range write is suppressed
    run_op(4'h5, 4'hF, 4'h3, 64'd8192, 64'h0, 4'h1, 0);
    run_op(4'h4, 4'hF, 4'hF, 64'd8192 + 64'h10, 64'hBAD, 4'h1, 0);
    run_op(4'h5, 4'hF, 4'h2, 64'h10, 64'h0, 4'h1, 0);
    // last valid word, valA-addressed read, error keeps non-AOK status
    run_op(4'h4, 4'hF, 4'hF, 64'd8191, 64'h1234, 4'h1, 0);
    run_op(4'h9, 4'h4, 4'hF, 64'h8, 64'd8191, 4'h1, 0);
    run_op(4'hB, 4'h4, 4'h6, 64'h8, 64'd8192, 4'h2, 0);
    // non-access op with all-ones operands
    run_op(4'h6, 4'h2, 4'hF, '1, '1, 4'h1, 0);
    // stall held four cycles in the middle of an access
    run_op(4'h8, 4'h4, 4'hF, 64'h40, 64'hCAFE_F00D, 4'h1, -1);
    run_op(4'hB, 4'h4, 4'h7, 64'h0, 64'h40, 4'h1, 0);

    // bubble replaces the W load with a NOP
    M_icode = 4'h6; M_dstE = 4'h2; M_dstM = 4'hF;
    M_valE = 64'h55; M_valA = 64'h66; M_stat = 4'h1;
    W_bubble = 1'b1;
    @(negedge clk);
    W_bubble = 1'b0;
    run_op(4'h6, 4'h2, 4'hF, 64'h55, 64'h66, 4'h1, 0);

    // reset aborts an in-flight write, at cycle 2 and at the commit cycle
    run_op(4'hA, 4'h4, 4'hF, 64'h20, 64'h1111, 4'h1, 0);
    reset_abort(2, 64'h20, 64'h2222);
    run_op(4'h5, 4'hF, 4'h1, 64'h20, 64'h0, 4'h1, 0);
    reset_abort(3, 64'h20, 64'h3333);

    // counter scenario: two reads, one write, one out-of-range read
    run_op(4'h5, 4'hF, 4'h1, 64'h20, 64'h0, 4'h1, 0);
    run_op(4'h4, 4'hF, 4'hF, 64'h30, 64'h77, 4'h1, 0);
    run_op(4'h5, 4'hF, 4'h1, 64'h30, 64'h0, 4'h1, 0);
    run_op(4'h5, 4'hF, 4'h1, 64'd8200, 64'h0, 4'h1, 0);
`ifdef MEM_PERF_CNT_EN
    check("rd_count_2",  64'(rd_count),  64'd2);
    check("wr_count_1",  64'(wr_count),  64'd1);
    check("err_count_1", 64'(err_count), 64'd1);
`endif

    // randomized traffic with random stalls
    for (int i = 0; i < 250; i++) begin
      ic = ics[$urandom_range(11)];
      st = ($urandom_range(3) == 0) ? 4'($urandom_range(4, 2)) : 4'h1;
      vE = {$urandom, $urandom};
      vA = {$urandom, $urandom};
      rdop = (ic == 4'h5) || (ic == 4'h9) || (ic == 4'hB);
      if (rdop && waddrs.size() == 0) begin
        ic = 4'h4;
        rdop = 1'b0;
      end
      wrop = (ic == 4'h4) || (ic == 4'h8) || (ic == 4'hA);
      if ($urandom_range(5) == 0) begin
        a = $urandom_range(1) ? 64'd8192 + 64'($urandom_range(1000))
                              : {$urandom | 32'h8000_0000, $urandom};
      end else if (wrop) begin
        a = ($urandom_range(7) == 0) ? 64'd8191 : 64'($urandom_range(63));
      end else begin
        a = waddrs[$urandom_range(waddrs.size() - 1)];
      end
      if (ic == 4'h9 || ic == 4'hB) vA = a;
      else if (rdop || wrop)       vE = a;
      run_op(ic, 4'($urandom_range(15)), 4'($urandom_range(15)), vE, vA, st, 20);
    end
    check_counters();

    set_idle();
    repeat (3) @(negedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
